// File: rtl/dbus_arbiter_rr_pkg.sv
// Shared types for the data-bus arbiter: CPU request/ROB types (cpu_defs) and
// arbiter-local state and grant-id encoding (dbus_arbiter_rr_pkg).
package cpu_defs;
  typedef logic [5:0] rob_index_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        invalidate;
    logic        invalidate_icache;
    logic        uncached;
  } data_memreq_t;
endpackage

package dbus_arbiter_rr_pkg;
  typedef enum logic {IDLE, HOLD} dbus_arb_state_t;

  // Grant ids 0..num_req-1 name load channels; id num_req names the store.
  function automatic int grant_store_id(input int num_req);
    return num_req;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/dbus_arbiter_rr_if.sv
// Data-bus interface shared by the cached and uncached buses.
interface cpu_dbus_if;
  logic [31:0] address;
  logic [31:0] wrdata;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic        invalidate;
  logic        invalidate_icache;
  logic        stall;

  modport master (output address, wrdata, byteenable, read, write,
                  invalidate, invalidate_icache, input stall);
  modport slave  (input address, wrdata, byteenable, read, write,
                  invalidate, invalidate_icache, output stall);
endinterface

// File: rtl/dbus_arbiter_rr_rr_pick.sv
// Rotating priority encoder: first set bit of mask scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] idx
);
  always_comb begin
    logic [PW:0] cand;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    cand  = '0;
    valid = 1'b0;
    idx   = '0;
    // Scan from the far end so the candidate closest to ptr overwrites last.
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW + 1)'(k);
      if (cand >= (PW + 1)'(N)) cand = cand - (PW + 1)'(N);
      if (mask[cand[PW-1:0]]) begin
        valid = 1'b1;
        idx   = cand[PW-1:0];
      end
    end
  end
endmodule

// File: rtl/dbus_arbiter_rr.sv
// Round-robin data-bus arbiter: store buffer vs NUM_REQ load channels, with a
// bounded store streak and a HOLD state across bus stalls. Optional: DBUS_ARB_PERF_EN.
module dbus_arbiter_rr
  import cpu_defs::*;
  import dbus_arbiter_rr_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int MAX_STORE_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  cpu_dbus_if.master         dbus,
  cpu_dbus_if.master         dbus_uncached,
  input  data_memreq_t       store_req,
  input  logic               store_valid,
  output logic               store_ready,
  input  data_memreq_t       ld_req [NUM_REQ],
  input  logic [NUM_REQ-1:0] ld_valid,
  output logic [NUM_REQ-1:0] ld_ready,
  input  rob_index_t         ld_reorder [NUM_REQ],
  input  rob_index_t         rob_reorder [2],
  input  logic               rob_head_busy
`ifdef DBUS_ARB_PERF_EN
  ,
  output logic [31:0]        perf_store_grants,
  output logic [31:0]        perf_load_grants,
  output logic [31:0]        perf_stall_cycles
`endif
);
  localparam int PW = clog2_min1(NUM_REQ);
  localparam int GW = clog2_min1(NUM_REQ + 1);
  localparam int SW = clog2_min1(MAX_STORE_STREAK + 1);
  localparam logic [GW-1:0] GRANT_STORE = GW'(grant_store_id(NUM_REQ));

  dbus_arb_state_t    state, state_next;
  logic [GW-1:0]      held_id;
  data_memreq_t       held_req;
  logic [PW-1:0]      rr_ptr;
  logic [SW-1:0]      streak;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [PW-1:0]      pick_idx;
  logic               streak_full, store_wins, win_valid;
  logic [GW-1:0]      win_id, cur_id;
  data_memreq_t       win_req, cur_req;
  logic               cur_valid, stall_any, accept, bus_on;
  logic [PW-1:0]      ld_idx;

  // Uncached loads may only go when they are at (or next to a retired) ROB head.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = ld_valid[i] && (!ld_req[i].uncached ||
                    (!store_valid && (ld_reorder[i] == rob_reorder[0] ||
                     (ld_reorder[i] == rob_reorder[1] && !rob_head_busy))));
    end
  end

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .mask  (eligible),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign streak_full = (MAX_STORE_STREAK != 0) && (streak == SW'(MAX_STORE_STREAK));
  assign store_wins  = store_valid && !(streak_full && pick_valid);
  assign win_valid   = store_wins || pick_valid;
  assign win_id      = store_wins ? GRANT_STORE : GW'(pick_idx);
  assign win_req     = store_wins ? store_req : ld_req[pick_idx];
  assign stall_any   = dbus.stall || dbus_uncached.stall;

  always_comb begin
    state_next = state;
    cur_valid  = 1'b0;
    cur_id     = win_id;
    cur_req    = win_req;
    unique case (state)
      IDLE: begin
        cur_valid = win_valid;
        if (win_valid && stall_any) state_next = HOLD;
      end
      HOLD: begin
        cur_valid = 1'b1;
        cur_id    = held_id;
        cur_req   = held_req;
        if (!stall_any) state_next = IDLE;
      end
    endcase
  end

  // Gating with rst_n drops ready and bus commands the instant reset asserts.
  assign accept      = cur_valid && !stall_any && rst_n;
  assign bus_on      = cur_valid && rst_n;
  assign store_ready = accept && (cur_id == GRANT_STORE);
  assign ld_idx      = cur_id[PW-1:0];

  always_comb begin
    ld_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) ld_ready[i] = accept && (cur_id == GW'(i));
  end

  assign dbus.read                       = bus_on && !cur_req.uncached && cur_req.read;
  assign dbus.write                      = bus_on && !cur_req.uncached && cur_req.write;
  assign dbus.invalidate                 = bus_on && !cur_req.uncached && cur_req.invalidate;
  assign dbus.invalidate_icache          = bus_on && !cur_req.uncached && cur_req.invalidate_icache;
  assign dbus_uncached.read              = bus_on && cur_req.uncached && cur_req.read;
  assign dbus_uncached.write             = bus_on && cur_req.uncached && cur_req.write;
  assign dbus_uncached.invalidate        = bus_on && cur_req.uncached && cur_req.invalidate;
  assign dbus_uncached.invalidate_icache = bus_on && cur_req.uncached && cur_req.invalidate_icache;
  assign dbus.address                    = cur_req.addr;
  assign dbus.wrdata                     = cur_req.wrdata;
  assign dbus.byteenable                 = cur_req.byteenable;
  assign dbus_uncached.address           = cur_req.addr;
  assign dbus_uncached.wrdata            = cur_req.wrdata;
  assign dbus_uncached.byteenable        = cur_req.byteenable;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      held_id  <= '0;
      // NOTE: the held request is a single register, not an array, so resetting it is cheap and keeps the bus quiet.
      held_req <= '0;
      rr_ptr   <= '0;
      streak   <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && win_valid && stall_any) begin
        held_id  <= win_id;
        held_req <= win_req;
      end
      if (accept) begin
        if (cur_id == GRANT_STORE) begin
          if (streak != SW'(MAX_STORE_STREAK)) streak <= streak + 1'b1;
        end else begin
          streak <= '0;
          rr_ptr <= (ld_idx == PW'(NUM_REQ - 1)) ? '0 : ld_idx + 1'b1;
        end
      end
    end
  end

`ifdef DBUS_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_store_grants <= '0;
      perf_load_grants  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (store_ready)   perf_store_grants <= perf_store_grants + 1'b1;
      if (|ld_ready)     perf_load_grants  <= perf_load_grants + 1'b1;
      if (state == HOLD) perf_stall_cycles <= perf_stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dbus_arbiter_rr.sv
// Scoreboard bench for dbus_arbiter_rr: the driver queues expected grants, a
// negedge monitor pops and compares each ready pulse.
module tb_dbus_arbiter_rr;
  import cpu_defs::*;

  typedef struct {
    int          id;
    bit          unc;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  data_memreq_t store_req;
  logic         store_valid, store_ready;
  data_memreq_t ld_req [4];
  logic [3:0]   ld_valid, ld_ready;
  rob_index_t   ld_reorder [4];
  rob_index_t   rob_reorder [2];
  logic         rob_head_busy;
`ifdef DBUS_ARB_PERF_EN
  logic [31:0]  perf_store_grants, perf_load_grants, perf_stall_cycles;
  logic [31:0]  ps0, pl0, pc0;
`endif

  cpu_dbus_if dbus_c ();
  cpu_dbus_if dbus_u ();

  dbus_arbiter_rr #(.NUM_REQ(4), .MAX_STORE_STREAK(4)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dbus              (dbus_c),
    .dbus_uncached     (dbus_u),
    .store_req         (store_req),
    .store_valid       (store_valid),
    .store_ready       (store_ready),
    .ld_req            (ld_req),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_reorder        (ld_reorder),
    .rob_reorder       (rob_reorder),
    .rob_head_busy     (rob_head_busy)
`ifdef DBUS_ARB_PERF_EN
    ,
    .perf_store_grants (perf_store_grants),
    .perf_load_grants  (perf_load_grants),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // id 4 is the store; loads use address 0x100 + 4*id.
  task automatic exp_grant(input int id, input int at);
    exp_t e;
    e.id   = id;
    e.unc  = (id == 4) ? 1'b0 : ld_req[id].uncached;
    e.addr = (id == 4) ? 32'h200 : 32'h100 + 32'(4 * id);
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    int   nr;
    int   gid;
    exp_t e;
    nr = $countones(ld_ready) + int'(store_ready);
    if (nr != 0) begin
      check("one_ready", nr, 1);
      gid = store_ready ? 4 : 0;
      for (int i = 0; i < 4; i++) if (ld_ready[i]) gid = i;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("grant_id", gid, e.id);
        check("grant_cycle", cyc, e.cyc);
        check("grant_addr", dbus_c.address, e.addr);
        if (e.id == 4) check("store_bus_write", {dbus_c.write, dbus_u.write}, 2'b10);
        else check("load_bus_read", {dbus_c.read, dbus_u.read}, e.unc ? 2'b01 : 2'b10);
      end
    end
  end

  initial begin
    int t;
    rst_n          = 1'b0;
    store_req      = '0;
    store_req.addr = 32'h200;
    store_req.wrdata = 32'hdead_beef;
    store_req.byteenable = 4'hf;
    store_req.write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ld_req[i]            = '0;
      ld_req[i].addr       = 32'h100 + 32'(4 * i);
      ld_req[i].byteenable = 4'hf;
      ld_req[i].read       = 1'b1;
      ld_reorder[i]        = rob_index_t'(10 + i);
    end
    rob_reorder[0] = 6'd0;
    rob_reorder[1] = 6'd1;
    rob_head_busy  = 1'b0;
    dbus_c.stall   = 1'b0;
    dbus_u.stall   = 1'b0;
    store_valid    = 1'b1;
    ld_valid       = 4'hF;

    // Reset: requests pending but everything must stay quiet.
    #12;
    check("rst_store_ready", store_ready, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_dbus_cmd", {dbus_c.read, dbus_c.write, dbus_c.invalidate, dbus_c.invalidate_icache}, 0);
    check("rst_dbus_unc_cmd", {dbus_u.read, dbus_u.write, dbus_u.invalidate, dbus_u.invalidate_icache}, 0);
    store_valid = 1'b0;
    ld_valid    = 4'h0;
    #1 rst_n = 1'b1;

    // 1: all four cached loads, no store, no stall -> 0,1,2,3,0.
    next_cycle();
    t = cyc;
    ld_valid = 4'hF;
    exp_grant(0, t); exp_grant(1, t + 1); exp_grant(2, t + 2); exp_grant(3, t + 3); exp_grant(0, t + 4);
    repeat (5) next_cycle();
    ld_valid = 4'h0;

    // 2: store streak of 4, then load 2, streak restarts from 0 (rr_ptr = 1).
    next_cycle();
    t = cyc;
    store_valid = 1'b1;
    ld_valid    = 4'b0100;
    for (int k = 0; k < 4; k++) exp_grant(4, t + k);
    exp_grant(2, t + 4);
    for (int k = 5; k < 9; k++) exp_grant(4, t + k);
    exp_grant(2, t + 9);
    repeat (10) next_cycle();
    store_valid = 1'b0;
    ld_valid    = 4'h0;

    // 3: store held through 3 stalled cycles, load 1 raised meanwhile.
    next_cycle();
    t = cyc;
`ifdef DBUS_ARB_PERF_EN
    ps0 = perf_store_grants;
    pl0 = perf_load_grants;
    pc0 = perf_stall_cycles;
`endif
    store_valid  = 1'b1;
    dbus_c.stall = 1'b1;
    #1;
    check("stall_store_ready", store_ready, 0);
    check("stall_bus_write", dbus_c.write, 1);
    next_cycle();
    ld_valid = 4'b0010;
    #1;
    check("hold_addr", dbus_c.address, 32'h200);
    check("hold_no_load_read", dbus_c.read, 0);
    check("hold_ld_ready", ld_ready, 0);
    next_cycle();
    next_cycle();
    dbus_c.stall = 1'b0;
    exp_grant(4, t + 3);
    exp_grant(1, t + 4);
    next_cycle();
    store_valid = 1'b0;
    next_cycle();
    ld_valid = 4'h0;
`ifdef DBUS_ARB_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles - pc0, 3);
    check("perf_store_grants", perf_store_grants - ps0, 1);
    check("perf_load_grants", perf_load_grants - pl0, 1);
`endif

    // 4: uncached load 0 at ROB head+1 (rr_ptr = 2).
    next_cycle();
    t = cyc;
    ld_req[0].uncached = 1'b1;
    ld_reorder[0]      = 6'd7;
    rob_reorder[0]     = 6'd6;
    rob_reorder[1]     = 6'd7;
    rob_head_busy      = 1'b1;
    ld_valid           = 4'b0001;
    #1;
    check("unc_blocked_ready", ld_ready, 0);
    check("unc_blocked_read", dbus_u.read, 0);
    next_cycle();
    next_cycle();
    rob_head_busy = 1'b0;
    exp_grant(0, t + 2);
    next_cycle();
    store_valid = 1'b1;
    exp_grant(4, t + 3);
    #1;
    check("unc_waits_for_store", ld_ready, 0);
    next_cycle();
    store_valid = 1'b0;
    exp_grant(0, t + 4);
    next_cycle();
    ld_valid           = 4'h0;
    ld_req[0].uncached = 1'b0;

    // 5: reset in HOLD (rr_ptr = 1 before reset).
    next_cycle();
    t = cyc;
    store_valid  = 1'b1;
    dbus_c.stall = 1'b1;
    next_cycle();
    check("pre_reset_hold_write", dbus_c.write, 1);
    #1;
    dbus_c.stall = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("reset_hold_store_ready", store_ready, 0);
    check("reset_hold_bus_write", {dbus_c.write, dbus_u.write}, 0);
    store_valid = 1'b0;
    next_cycle();
    ld_valid = 4'hF;
    #1;
    check("reset_hold_ld_ready", ld_ready, 0);
    rst_n = 1'b1;
    exp_grant(0, t + 2);
    next_cycle();
    ld_valid = 4'h0;

    repeat (3) next_cycle();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter_rr.md
Name: dbus_arbiter_rr

Overview:
Parametrised data-bus arbiter between the store buffer and NUM_REQ LSU reservation-station load channels. It drives the cached and uncached data buses. Round-robin fairness among loads and a bounded store-priority streak replace the fixed-priority scheme. A HOLD state freezes the granted request across bus stalls, and ready is issued only when the bus accepts. It sits between the LSU reservation stations / store buffer and the dcache / uncached bus.

Parameters:
NUM_REQ, 4, number of load channels (>=1; pointer width $clog2(NUM_REQ), min 1)
MAX_STORE_STREAK, 4, consecutive store grants allowed while an eligible load waits; 0 = store always wins

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dbus  if  cpu_dbus_if.master  cached data bus
dbus_uncached  if  cpu_dbus_if.master  uncached data bus
store_req  in  data_memreq_t  store-buffer request
store_valid  in  1  store request pending
store_ready  out  1  store request accepted this cycle
ld_req  in  data_memreq_t[NUM_REQ]  load requests
ld_valid  in  NUM_REQ  load request pending
ld_ready  out  NUM_REQ  load accepted this cycle (one-hot or zero)
ld_reorder  in  rob_index_t[NUM_REQ]  ROB index of each load
rob_reorder  in  rob_index_t[2]  ROB head and head+1 indices
rob_head_busy  in  1  ROB head entry still busy

Behaviour:
- Reset values: store_ready=0, ld_ready=0, all bus read/write/invalidate/invalidate_icache=0, state=IDLE, rr_ptr=0, streak=0.
- Load eligibility: ld_valid[i] && (!ld_req[i].uncached || (!store_valid && (ld_reorder[i]==rob_reorder[0] || (ld_reorder[i]==rob_reorder[1] && !rob_head_busy)))).
- Load pick: first eligible index scanning rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
- Store vs load: the store wins if store_valid, unless MAX_STORE_STREAK!=0 && streak==MAX_STORE_STREAK && an eligible load exists.
- Bus routing: the winner's request goes to dbus if !uncached, else to dbus_uncached. Read/write on the other bus stay 0. Data, address and byteenable are fanned to both buses.
- IDLE:
  - No winner: bus idle.
  - Winner and both bus stalls low: pulse the winner's ready this cycle (0-cycle latency); stay in IDLE.
  - Winner and either stall high: latch the winner id and request, assert no ready, go to HOLD.
- HOLD:
  - Drive the latched request every cycle; no arbitration, and a new store does not preempt.
  - On the first cycle with both stalls low: pulse ready to the latched id, return to IDLE. No new grant that cycle.
  - Requesters keep valid high until ready; a held request is not withdrawn.
- rr_ptr: on a load ready for index w, rr_ptr <= (w+1) mod NUM_REQ. Unchanged otherwise.
- streak:
  - On store ready: streak <= min(streak+1, MAX_STORE_STREAK).
  - On load ready: streak <= 0.
  - No change while no eligible load is waiting and a store is granted past saturation (stays saturated).
- At most one ready per cycle across all channels.
- Reset asserted mid-HOLD: state drops to IDLE immediately; the latched request is discarded; bus commands drop to 0 asynchronously.
- NUM_REQ=1: rr_ptr is constant 0; fairness logic degenerates correctly.

Optional Feature:
DBUS_ARB_PERF_EN.
- Defined: adds outputs perf_store_grants, perf_load_grants and perf_stall_cycles, each 32 bits. They are wrapping counters, reset to 0, incremented respectively on store_ready, on any ld_ready, and on each HOLD cycle.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: dbus_arb_state_t enum (IDLE, HOLD) and the DBUS_ARB_GRANT_STORE encoding constant (grant id = NUM_REQ denotes the store).
- data_memreq_t and rob_index_t come from the existing cpu_defs.
- One sub-module: rr_pick (NUM_REQ-wide rotating priority encoder: mask, ptr → valid + index).

Test Plan:
1. Loads 0,1,2,3 continuously valid and cached, no store, no stall → ld_ready order 0,1,2,3,0; rr_ptr ends at 1.
2. store_valid held high, ld_valid[2]=1 cached, MAX_STORE_STREAK=4 → 4 store_ready pulses, then ld_ready[2], then store resumes; streak returns to 0 after the load.
3. Store granted with dbus.stall high for 3 cycles; load 1 raised meanwhile → request held 3 cycles, then store_ready on cycle 4; ld_ready[1] only on cycle 5.
4. Uncached load 0 with ld_reorder=7:
   - rob_reorder={6,7}, rob_head_busy=1 → no grant.
   - rob_head_busy drops → ld_ready[0] on dbus_uncached.read.
   - Repeat with store_valid=1 → store wins; the load waits.
5. rst_n pulled low in HOLD → ready and bus commands go to 0 immediately; after release, rr_ptr=0 and load 0 wins first.
6. With DBUS_ARB_PERF_EN, run scenario 3 → perf_stall_cycles=3, perf_store_grants=1, perf_load_grants=1.
